// File: rtl/wish_pkg.sv
// Shared definitions for the wish_* width converters: tag bit positions and FSM encodings.
package wish_pkg;

    localparam int TGC_FIRST_BIT = 0;
    localparam int TGC_LAST_BIT  = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/wish_skid.sv
// One-entry registered skid buffer; passes through when empty and downstream is ready.
// in_rdy is a pure flop output (low only while the entry holds a word).
module wish_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat
);

    logic             full;
    logic [WIDTH-1:0] hold_dat;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            full     <= 1'b0;
            hold_dat <= '0;
        end else if (!full && in_vld && !out_rdy) begin
            full     <= 1'b1;
            hold_dat <= in_dat;
        end else if (full && out_rdy) begin
            full     <= 1'b0;
        end
    end

    assign in_rdy  = !full;
    assign out_vld = full || in_vld;
    assign out_dat = full ? hold_dat : in_dat;

endmodule

// File: rtl/wish_unpack.sv
// Splits one wide word into NUM_PACK narrow beats, moving first/last tag bits to the edge beats.
// 1 cycle accept-to-first-beat; WISH_UNPACK_SKID_EN adds a skid entry so s_stall_o is a flop output.
module wish_unpack
    import wish_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_PACK      = 4,
    parameter int TGC_WIDTH     = 2,
    parameter int LITTLE_ENDIAN = 0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           s_stb_i,
    input  logic                           s_cyc_i,
    input  logic [DATA_WIDTH*NUM_PACK-1:0] s_dat_i,
    input  logic [TGC_WIDTH-1:0]           s_tgc_i,
    output logic                           s_stall_o,
    output logic                           s_ack_o,
    output logic                           d_stb_o,
    output logic                           d_cyc_o,
    output logic [DATA_WIDTH-1:0]          d_dat_o,
    output logic [TGC_WIDTH-1:0]           d_tgc_o,
    input  logic                           d_ack_i
);

    localparam int WIDE_WIDTH = DATA_WIDTH * NUM_PACK;
    localparam int IDX_WIDTH  = (NUM_PACK > 1) ? $clog2(NUM_PACK) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_PACK - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_WIDTH-1:0]    beat_idx;
    logic [WIDE_WIDTH-1:0]   shreg;
    logic [TGC_WIDTH-1:0]    tag_q;
    logic                    busy;
    logic                    final_beat;
    logic                    unp_rdy;
    logic                    ld_vld;
    logic                    load;
    logic                    in_acc;
    logic [WIDE_WIDTH-1:0]   ld_dat;
    logic [TGC_WIDTH-1:0]    ld_tgc;
    logic [DATA_WIDTH-1:0]   cur_slice;

    assign busy       = (state == ST_BUSY);
    assign final_beat = busy && (beat_idx == LAST_IDX) && d_ack_i;
    // The unpacker can take a new word when idle or while its last beat leaves.
    assign unp_rdy    = !busy || final_beat;
    assign load       = ld_vld && unp_rdy;

`ifdef WISH_UNPACK_SKID_EN
    logic                            skid_rdy;
    logic [WIDE_WIDTH+TGC_WIDTH-1:0] skid_out;

    wish_skid #(
        .WIDTH (WIDE_WIDTH + TGC_WIDTH)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .in_vld  (s_cyc_i && s_stb_i),
        .in_rdy  (skid_rdy),
        .in_dat  ({s_tgc_i, s_dat_i}),
        .out_vld (ld_vld),
        .out_rdy (unp_rdy),
        .out_dat (skid_out)
    );

    assign ld_dat    = skid_out[WIDE_WIDTH-1:0];
    assign ld_tgc    = skid_out[WIDE_WIDTH +: TGC_WIDTH];
    assign s_stall_o = !skid_rdy;
    assign in_acc    = s_cyc_i && s_stb_i && skid_rdy;
`else
    assign ld_vld    = s_cyc_i && s_stb_i;
    assign ld_dat    = s_dat_i;
    assign ld_tgc    = s_tgc_i;
    assign s_stall_o = !unp_rdy;
    assign in_acc    = load;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (load) state_nxt = ST_BUSY;
            ST_BUSY: if (final_beat) state_nxt = load ? ST_BUSY : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s_ack_o  <= 1'b0;
            beat_idx <= '0;
            shreg    <= '0;
            tag_q    <= '0;
        end else begin
            s_ack_o <= in_acc;
            if (load) begin
                shreg    <= ld_dat;
                tag_q    <= ld_tgc;
                beat_idx <= '0;
            end else if (busy && d_ack_i) begin
                shreg    <= (LITTLE_ENDIAN != 0) ? (shreg >> DATA_WIDTH) : (shreg << DATA_WIDTH);
                beat_idx <= beat_idx + IDX_WIDTH'(1);
            end
        end
    end

    assign cur_slice = (LITTLE_ENDIAN != 0) ? shreg[DATA_WIDTH-1:0]
                                            : shreg[WIDE_WIDTH-1 -: DATA_WIDTH];

    assign d_stb_o = busy;
    assign d_cyc_o = busy;
    assign d_dat_o = busy ? cur_slice : '0;

    // User tag bits ride on every beat; first/last only on the edge beats.
    always_comb begin
        d_tgc_o = '0;
        if (busy) begin
            d_tgc_o                = tag_q;
            d_tgc_o[TGC_FIRST_BIT] = tag_q[TGC_FIRST_BIT] && (beat_idx == '0);
            d_tgc_o[TGC_LAST_BIT]  = tag_q[TGC_LAST_BIT] && (beat_idx == LAST_IDX);
        end
    end

endmodule

// File: tb/tb_wish_unpack.sv
// Two DUTs (MSB-first and LSB-first) share stimulus; a scoreboard checks beats, acks and timing.
module tb_wish_unpack;

    localparam int DW = 8;
    localparam int NP = 4;
    localparam int TW = 3;
    localparam int WW = DW * NP;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          s_stb_i = 1'b0;
    logic          s_cyc_i = 1'b0;
    logic [WW-1:0] s_dat_i = '0;
    logic [TW-1:0] s_tgc_i = '0;
    logic          d_ack_i = 1'b0;

    logic          stall0, ack0, stb0, cyc0;
    logic [DW-1:0] dat0;
    logic [TW-1:0] tgc0;
    logic          stall1, ack1, stb1, cyc1;
    logic [DW-1:0] dat1;
    logic [TW-1:0] tgc1;

    int checks = 0;
    int failures = 0;
    int ack_mode = 0;   // 0: ack held high, 1: random ack, 2: driven by main sequence

    typedef struct packed {
        logic [DW-1:0] dat;
        logic [TW-1:0] tgc;
    } beat_t;

    beat_t exp_q0[$];
    beat_t exp_q1[$];
    bit    exp_ack = 1'b0;
    int    rem = 0;

    wish_unpack #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TW), .LITTLE_ENDIAN(0)) dut0 (
        .clk_i(clk), .rst_i(rst_i), .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i),
        .s_dat_i(s_dat_i), .s_tgc_i(s_tgc_i), .s_stall_o(stall0), .s_ack_o(ack0),
        .d_stb_o(stb0), .d_cyc_o(cyc0), .d_dat_o(dat0), .d_tgc_o(tgc0), .d_ack_i(d_ack_i));

    wish_unpack #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TW), .LITTLE_ENDIAN(1)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i),
        .s_dat_i(s_dat_i), .s_tgc_i(s_tgc_i), .s_stall_o(stall1), .s_ack_o(ack1),
        .d_stb_o(stb1), .d_cyc_o(cyc1), .d_dat_o(dat1), .d_tgc_o(tgc1), .d_ack_i(d_ack_i));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s t=%0t", name, $time);
    endtask

    // Beat k of a wide word, straight from the slice-order and tag rules.
    function automatic beat_t model_beat(input logic [WW-1:0] w, input logic [TW-1:0] t,
                                         input int k, input bit le);
        beat_t b;
        int    pos;
        pos    = le ? k : (NP - 1 - k);
        b.dat  = w[pos*DW +: DW];
        b.tgc  = t;
        b.tgc[0] = t[0] && (k == 0);
        b.tgc[1] = t[1] && (k == NP - 1);
        return b;
    endfunction

    // Stimulus side: every accepted word pushes its expected beats.
    always @(negedge clk) begin
        if (!rst_i) begin
            exp_q0.delete();
            exp_q1.delete();
        end else if (s_cyc_i && s_stb_i && !stall0) begin
            for (int k = 0; k < NP; k++) begin
                exp_q0.push_back(model_beat(s_dat_i, s_tgc_i, k, 1'b0));
                exp_q1.push_back(model_beat(s_dat_i, s_tgc_i, k, 1'b1));
            end
        end
    end

    // Monitor: pops on every transferred beat, checks ack timing and idle outputs.
    always @(negedge clk) begin
        bit    acc;
        beat_t e;
        if (!rst_i) begin
            exp_ack = 1'b0;
            rem     = 0;
        end else begin
            acc = s_cyc_i && s_stb_i && !stall0;
            chk("s_ack0", ack0, exp_ack);
            chk("s_ack1", ack1, exp_ack);
`ifndef WISH_UNPACK_SKID_EN
            chk("d_stb0", stb0, rem > 0);
            chk("d_stb1", stb1, rem > 0);
            chk("s_stall0", stall0, (rem > 1) || (rem == 1 && !d_ack_i));
            chk("s_stall1", stall1, (rem > 1) || (rem == 1 && !d_ack_i));
`endif
            if (stb0) begin
                chk("d_cyc0", cyc0, 1);
                if (d_ack_i) begin
                    if (exp_q0.size() == 0) fail_now("beat0_unexpected");
                    else begin
                        e = exp_q0.pop_front();
                        chk("beat0_dat", dat0, e.dat);
                        chk("beat0_tgc", tgc0, e.tgc);
                    end
                end
            end else begin
                chk("idle0_cyc", cyc0, 0);
                chk("idle0_dat", dat0, 0);
                chk("idle0_tgc", tgc0, 0);
            end
            if (stb1) begin
                chk("d_cyc1", cyc1, 1);
                if (d_ack_i) begin
                    if (exp_q1.size() == 0) fail_now("beat1_unexpected");
                    else begin
                        e = exp_q1.pop_front();
                        chk("beat1_dat", dat1, e.dat);
                        chk("beat1_tgc", tgc1, e.tgc);
                    end
                end
            end else begin
                chk("idle1_cyc", cyc1, 0);
                chk("idle1_dat", dat1, 0);
                chk("idle1_tgc", tgc1, 0);
            end
            exp_ack = acc;
            if (acc) rem = NP;
            else if (rem > 0 && d_ack_i) rem = rem - 1;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ack_mode == 0) d_ack_i = 1'b1;
            else if (ack_mode == 1) d_ack_i = 1'($urandom_range(0, 3) != 0);
        end
    end

    task automatic idle(input int n);
        s_stb_i = 1'b0;
        s_cyc_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents a word from posedge+1 until it is accepted; returns at posedge+1 with stb still high.
    task automatic send(input logic [WW-1:0] d, input logic [TW-1:0] t);
        bit acc;
        int n;
        s_cyc_i = 1'b1;
        s_stb_i = 1'b1;
        s_dat_i = d;
        s_tgc_i = t;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = !stall0;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) fail_now("send_timeout");
    endtask

    task automatic wait_dat0(input logic [DW-1:0] v, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(stb0 && dat0 == v) && n < 50);
        if (!(stb0 && dat0 == v)) fail_now(name);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall0"}, stall0, 0); chk({tag, "_ack0"}, ack0, 0);
        chk({tag, "_stb0"}, stb0, 0);     chk({tag, "_cyc0"}, cyc0, 0);
        chk({tag, "_dat0"}, dat0, 0);     chk({tag, "_tgc0"}, tgc0, 0);
        chk({tag, "_stall1"}, stall1, 0); chk({tag, "_ack1"}, ack1, 0);
        chk({tag, "_stb1"}, stb1, 0);     chk({tag, "_cyc1"}, cyc1, 0);
        chk({tag, "_dat1"}, dat1, 0);     chk({tag, "_tgc1"}, tgc1, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_i = 1'b1;
        idle(2);

        // Single word, ack held high.
        send(32'h11223344, 3'b011);
        idle(8);

        // Back-to-back words.
        send(32'hAABBCCDD, 3'b111);
        send(32'h01020304, 3'b011);
        idle(10);

        // Backpressure while beat 0x22 is presented.
        ack_mode = 2;
        d_ack_i  = 1'b1;
        send(32'h11223344, 3'b101);
        s_stb_i = 1'b0;
        s_cyc_i = 1'b0;
        wait_dat0(8'h11, "bp_wait_11");
        @(posedge clk);
        #1;
        d_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_dat", dat0, 8'h22);
            chk("bp_hold_stb", stb0, 1);
`ifndef WISH_UNPACK_SKID_EN
            chk("bp_hold_stall", stall0, 1);
`endif
            @(posedge clk);
            #1;
        end
        d_ack_i  = 1'b1;
        ack_mode = 0;
        idle(8);

        // Reset in the middle of a word.
        send(32'h11223344, 3'b111);
        s_stb_i = 1'b0;
        s_cyc_i = 1'b0;
        wait_dat0(8'h22, "rst_wait_22");
        @(posedge clk);
        #2;
        rst_i = 1'b0;
        #1;
        check_all_zero("midrst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        idle(8);

        // Strobe without cycle must be ignored.
        s_cyc_i = 1'b0;
        s_stb_i = 1'b1;
        s_dat_i = 32'hDEADBEEF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("nocyc_ack", ack0, 0);
            chk("nocyc_stb", stb0, 0);
        end
        idle(2);

        // Randomized traffic with random downstream ack.
        ack_mode = 1;
        for (int w = 0; w < 60; w++) begin
            send(WW'($urandom), TW'($urandom));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
        end
        idle(2);
        ack_mode = 0;
        idle(20);

        chk("drain_q0", exp_q0.size(), 0);
        chk("drain_q1", exp_q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
